// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the IF->ID pipeline bundle.
//  - Default field widths and the derived bundle width.
//  - Bit offsets of each field inside the default bundle (MSB..LSB):
//      pc | pc_4 | instr | wr_en | wr_addr | wr_data
//  - NOP instruction presented to ID while the receive buffer is empty.
//  - bundle_width(): derives the packed bundle width from field widths so
//    parameterised users never hand-compute it.
package pipe_pkg;

  localparam int unsigned DEF_PC_W    = 32;
  localparam int unsigned DEF_INSTR_W = 32;
  localparam int unsigned DEF_REG_AW  = 5;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_FLCNT_W = 8;

  function automatic int unsigned bundle_width(
    input int unsigned pc_w,
    input int unsigned instr_w,
    input int unsigned reg_aw,
    input int unsigned data_w
  );
    return 2 * pc_w + instr_w + 1 + reg_aw + data_w;
  endfunction

  localparam int unsigned DEF_BUNDLE_W =
    bundle_width(DEF_PC_W, DEF_INSTR_W, DEF_REG_AW, DEF_DATA_W);

  // Field offsets for the default layout (LSB position of each field).
  localparam int unsigned DEF_WR_DATA_LSB = 0;
  localparam int unsigned DEF_WR_ADDR_LSB = DEF_WR_DATA_LSB + DEF_DATA_W;
  localparam int unsigned DEF_WR_EN_BIT   = DEF_WR_ADDR_LSB + DEF_REG_AW;
  localparam int unsigned DEF_INSTR_LSB   = DEF_WR_EN_BIT + 1;
  localparam int unsigned DEF_PC_4_LSB    = DEF_INSTR_LSB + DEF_INSTR_W;
  localparam int unsigned DEF_PC_LSB      = DEF_PC_4_LSB + DEF_PC_W;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_skid_fifo.sv
// pipe_skid_fifo: 2-entry FIFO with valid/ready handshake and synchronous flush.
// Ports:
//  clk_i       in   clock, rising edge
//  rst_n_i     in   asynchronous active-low reset
//  flush_i     in   drop all entries, suppress same-cycle push/pop
//  wr_valid_i  in   write side has data
//  wr_data_i   in   write data (only sampled on an accepted push)
//  wr_ready_o  out  registered: FIFO can accept this cycle
//  rd_ready_i  in   read side consumes head this cycle
//  rd_valid_o  out  head entry valid (count != 0)
//  rd_data_o   out  head entry
//  count_o     out  occupancy 0..2
module pipe_skid_fifo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             wr_valid_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             wr_ready_o,
  input  logic             rd_ready_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             ready_q, ready_d;
  logic             push, pop;

  assign push = wr_valid_i & ready_q & ~flush_i;
  assign pop  = (count_q != 2'd0) & rd_ready_i & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
    // Ready is registered from next occupancy, so a full FIFO never accepts.
    ready_d = (count_d < 2'd2);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // Storage written only on an accepted push, so junk on wr_data_i while
  // wr_valid_i is low never lands in the array.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign wr_ready_o = ready_q;
  assign rd_valid_o = (count_q != 2'd0);
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/if_bundle_rx.sv
// if_bundle_rx: receiving end of the IF pipeline bundle.
// Buffers {pc, pc_4, instr, wr_en, wr_addr, wr_data} bundles in a 2-entry
// FIFO, unpacks the head for ID, substitutes a NOP bubble when empty and
// counts bundles discarded by flush (saturating).
// Ports:
//  clk, reset (async active-low)
//  in_bundle/in_valid/in_ready   : bundle input handshake (in_ready registered)
//  flush                          : discard buffered and incoming bundles
//  out_ready/out_valid            : head consume handshake
//  out_pc .. out_wr_data          : unpacked head fields (bubble when empty)
//  count                          : occupancy 0..2
//  flush_drops                    : saturating count of flushed valid entries
module if_bundle_rx
  import pipe_pkg::*;
#(
  parameter int unsigned PC_W    = DEF_PC_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W,
  parameter int unsigned REG_AW  = DEF_REG_AW,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned FLCNT_W = DEF_FLCNT_W,
  localparam int unsigned BUNDLE_W = bundle_width(PC_W, INSTR_W, REG_AW, DATA_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BUNDLE_W-1:0] in_bundle,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [PC_W-1:0]     out_pc,
  output logic [PC_W-1:0]     out_pc_4,
  output logic [INSTR_W-1:0]  out_instr,
  output logic                out_wr_en,
  output logic [REG_AW-1:0]   out_wr_addr,
  output logic [DATA_W-1:0]   out_wr_data,
  output logic [1:0]          count,
  output logic [FLCNT_W-1:0]  flush_drops
);

  localparam int unsigned WR_DATA_LSB = 0;
  localparam int unsigned WR_ADDR_LSB = WR_DATA_LSB + DATA_W;
  localparam int unsigned WR_EN_BIT   = WR_ADDR_LSB + REG_AW;
  localparam int unsigned INSTR_LSB   = WR_EN_BIT + 1;
  localparam int unsigned PC_4_LSB    = INSTR_LSB + INSTR_W;
  localparam int unsigned PC_LSB      = PC_4_LSB + PC_W;
  localparam int unsigned CW          = FLCNT_W + 1;

  logic [BUNDLE_W-1:0] head;
  logic                fifo_valid;
  logic                fifo_ready;
  logic [1:0]          fifo_count;
  logic [FLCNT_W-1:0]  flush_drops_q, flush_drops_d;
  logic [CW-1:0]       drop_sum;

  pipe_skid_fifo #(
    .WIDTH(BUNDLE_W)
  ) u_fifo (
    .clk_i      (clk),
    .rst_n_i    (reset),
    .flush_i    (flush),
    .wr_valid_i (in_valid),
    .wr_data_i  (in_bundle),
    .wr_ready_o (fifo_ready),
    .rd_ready_i (out_ready),
    .rd_valid_o (fifo_valid),
    .rd_data_o  (head),
    .count_o    (fifo_count)
  );

  // Empty FIFO presents a bubble: NOP instruction and no regfile write.
  always_comb begin
    out_pc      = '0;
    out_pc_4    = '0;
    out_instr   = INSTR_W'(NOP_INSTR);
    out_wr_en   = 1'b0;
    out_wr_addr = '0;
    out_wr_data = '0;
    if (fifo_valid) begin
      out_pc      = head[PC_LSB      +: PC_W];
      out_pc_4    = head[PC_4_LSB    +: PC_W];
      out_instr   = head[INSTR_LSB   +: INSTR_W];
      out_wr_en   = head[WR_EN_BIT];
      out_wr_addr = head[WR_ADDR_LSB +: REG_AW];
      out_wr_data = head[WR_DATA_LSB +: DATA_W];
    end
  end

  // A flush discards everything buffered plus the bundle that would have
  // been accepted this cycle; one extra bit catches the saturation carry.
  always_comb begin
    drop_sum      = {1'b0, flush_drops_q} + CW'(fifo_count) + CW'(in_valid & fifo_ready);
    flush_drops_d = flush_drops_q;
    if (flush) begin
      flush_drops_d = drop_sum[FLCNT_W] ? '1 : drop_sum[FLCNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_drops_q <= '0;
    end else begin
      flush_drops_q <= flush_drops_d;
    end
  end

  assign in_ready    = fifo_ready;
  assign out_valid   = fifo_valid;
  assign count       = fifo_count;
  assign flush_drops = flush_drops_q;

endmodule

// File: tb/tb_if_bundle_rx.sv
// tb_if_bundle_rx: self-checking bench for if_bundle_rx.
// A queue-based reference model tracks the FIFO contents, ready flag and
// flush drop counter; directed table rows, hand-written flush/reset
// sequences and a randomized phase are all checked against it.
module tb_if_bundle_rx;

  localparam int BW = 134;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [BW-1:0] in_bundle = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_pc_4;
  logic [31:0]   out_instr;
  logic          out_wr_en;
  logic [4:0]    out_wr_addr;
  logic [31:0]   out_wr_data;
  logic [1:0]    count;
  logic [7:0]    flush_drops;

  if_bundle_rx dut (
    .clk         (clk),
    .reset       (reset),
    .in_bundle   (in_bundle),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_pc_4    (out_pc_4),
    .out_instr   (out_instr),
    .out_wr_en   (out_wr_en),
    .out_wr_addr (out_wr_addr),
    .out_wr_data (out_wr_data),
    .count       (count),
    .flush_drops (flush_drops)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [BW-1:0] mq[$];
  bit            m_ready = 1'b0;
  int unsigned   m_drops = 0;

  typedef struct {
    bit          iv;
    bit          fl;
    bit          ordy;
    logic [31:0] pc;
    logic [31:0] instr;
    bit          wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    int          exp_cnt;
    bit          exp_ov;
    bit          exp_ir;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [BW-1:0] mk(input logic [31:0] pc, input logic [31:0] instr,
                                       input bit wen, input logic [4:0] wa,
                                       input logic [31:0] wd);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    return {pc, pc4, instr, wen, wa, wd};
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ready = 1'b0;
    m_drops = 0;
  endtask

  task automatic check_model();
    logic [BW-1:0] exp_head;
    logic [BW-1:0] act_head;
    exp_head = {32'h0, 32'h0, 32'h0000_0013, 1'b0, 5'h0, 32'h0};
    if (mq.size() != 0) exp_head = mq[0];
    act_head = {out_pc, out_pc_4, out_instr, out_wr_en, out_wr_addr, out_wr_data};
    chk("count", count, mq.size());
    chk("out_valid", out_valid, mq.size() != 0);
    chk("in_ready", in_ready, m_ready);
    chk("flush_drops", flush_drops, m_drops);
    chk("head", act_head, exp_head);
  endtask

  // Drive inputs, take one clock edge, advance the model, then check.
  task automatic step(input bit iv, input logic [BW-1:0] b, input bit fl, input bit ordy);
    bit          push, pop;
    int unsigned s;
    in_valid  = iv;
    in_bundle = b;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    push = iv && m_ready && !fl;
    pop  = (mq.size() != 0) && ordy && !fl;
    if (fl) begin
      s = m_drops + mq.size() + ((iv && m_ready) ? 1 : 0);
      m_drops = (s > 255) ? 255 : s;
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(b);
    end
    m_ready = (mq.size() < 2);
    #1;
    check_model();
  endtask

  initial begin
    logic [159:0] rnd;

    // Directed table: single push, back-to-back fill with hold-off,
    // in-order drain and push+pop at count 1.
    tbl.push_back('{0, 0, 0, 32'h0,   32'h0,        0, 5'd0, 32'h0,  0, 0, 1, 32'h0,   32'h0000_0013});
    tbl.push_back('{1, 0, 0, 32'h100, 32'h00500093, 1, 5'd5, 32'hAB, 1, 1, 1, 32'h100, 32'h00500093});
    tbl.push_back('{1, 0, 0, 32'h104, 32'h00A00113, 1, 5'd2, 32'h11, 2, 1, 0, 32'h100, 32'h00500093});
    tbl.push_back('{1, 0, 0, 32'h108, 32'h00F00193, 1, 5'd3, 32'h22, 2, 1, 0, 32'h100, 32'h00500093});
    tbl.push_back('{1, 0, 1, 32'h108, 32'h00F00193, 1, 5'd3, 32'h22, 1, 1, 1, 32'h104, 32'h00A00113});
    tbl.push_back('{1, 0, 1, 32'h108, 32'h00F00193, 1, 5'd3, 32'h22, 1, 1, 1, 32'h108, 32'h00F00193});
    tbl.push_back('{0, 0, 1, 32'h0,   32'h0,        0, 5'd0, 32'h0,  0, 0, 1, 32'h0,   32'h0000_0013});

    // Reset held for 3 cycles
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_instr", out_instr, 32'h0000_0013);
    chk("rst_count", count, 2'd0);
    chk("rst_drops", flush_drops, 8'd0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready_pre_edge", in_ready, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].iv, mk(tbl[i].pc, tbl[i].instr, tbl[i].wen, tbl[i].wa, tbl[i].wd),
           tbl[i].fl, tbl[i].ordy);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].exp_ov);
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].exp_ir);
      chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_instr", i), out_instr, tbl[i].exp_instr);
      if (i == 1) begin
        chk("single_pc_4", out_pc_4, 32'h104);
        chk("single_wr_en", out_wr_en, 1'b1);
        chk("single_wr_addr", out_wr_addr, 5'd5);
        chk("single_wr_data", out_wr_data, 32'hAB);
      end
    end

    // Flush with FIFO full and in_valid high: incoming not accepted
    step(1, mk(32'h200, 32'h1, 1, 5'd1, 32'h1), 0, 0);
    step(1, mk(32'h204, 32'h2, 1, 5'd2, 32'h2), 0, 0);
    step(1, mk(32'h208, 32'h3, 1, 5'd3, 32'h3), 1, 0);
    chk("flush_full_drops", flush_drops, 8'd2);
    chk("flush_full_count", count, 2'd0);
    chk("flush_full_valid", out_valid, 1'b0);
    chk("flush_full_ready", in_ready, 1'b1);

    // Flush at count 1 with an acceptable incoming bundle: both counted
    step(1, mk(32'h300, 32'h4, 0, 5'd4, 32'h4), 0, 0);
    step(1, mk(32'h304, 32'h5, 0, 5'd5, 32'h5), 1, 1);
    chk("flush_one_drops", flush_drops, 8'd4);
    chk("flush_one_ready", in_ready, 1'b1);

    // Drive the drop counter into saturation
    for (int k = 0; k < 126; k++) begin
      step(1, mk(32'h400 + k, 32'h6, 1, 5'd6, k), 0, 0);
      step(1, mk(32'h500 + k, 32'h7, 1, 5'd7, k), 0, 0);
      step(1, mk(32'h600 + k, 32'h8, 1, 5'd8, k), 1, 0);
    end
    chk("drops_saturated", flush_drops, 8'hFF);
    step(1, mk(32'h700, 32'h9, 1, 5'd9, 32'h9), 0, 0);
    step(0, '0, 1, 0);
    chk("drops_hold_sat", flush_drops, 8'hFF);

    // Async reset mid-stream with FIFO full
    step(1, mk(32'h800, 32'hA, 1, 5'd10, 32'hA), 0, 0);
    step(1, mk(32'h804, 32'hB, 1, 5'd11, 32'hB), 0, 0);
    chk("pre_reset_count", count, 2'd2);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_rst_count", count, 2'd0);
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_ready", in_ready, 1'b0);
    chk("async_rst_drops", flush_drops, 8'd0);
    chk("async_rst_instr", out_instr, 32'h0000_0013);
    chk("async_rst_wr_en", out_wr_en, 1'b0);
    reset = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      step($urandom_range(0, 3) != 0, rnd[BW-1:0], $urandom_range(0, 15) == 0,
           $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
